// File: rtl/alureg_seq.sv
// alureg_seq: opcode-sequenced register file and ALU (8085 register/immediate subset).
// One opcode per handshake; temp load, operand read, ALU and write-back are sequenced here.
// Optional build macro ALUREG_SEQ_ROTATE_EN adds RLC/RRC/RAL/RAR (0x07/0x0F/0x17/0x1F).
module alureg_seq #(
    parameter int DATASIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          code_in,
    input  logic                code_stb,
    input  logic [DATASIZE-1:0] data_in,
    input  logic                data_stb,
    input  logic [2:0]          rd_sel,
    output logic [DATASIZE-1:0] rd_out,
    output logic [DATASIZE-1:0] acc_out,
    output logic [DATASIZE-1:0] flag_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_WAITD, ST_READ, ST_WRITE, ST_DONE} state_t;
    typedef enum logic [2:0] {K_BAD, K_MOV, K_MVI, K_ALU, K_ALUI, K_ROT} kind_t;

    // Register slots follow the rd_sel numbering: 0..5 = B..L, 6 = F, 7 = A.
    localparam int F_IDX = 6;
    localparam int A_IDX = 7;
    localparam logic [DATASIZE-1:0] F_RESET = {{(DATASIZE-2){1'b0}}, 2'b10};

    state_t              state_r;
    logic [7:0]          code_r;
    logic [DATASIZE-1:0] temp_r;
    logic [DATASIZE-1:0] res_r;
    logic [DATASIZE-1:0] flg_r;
    logic [DATASIZE-1:0] regs_r [0:7];
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    kind_t               kind_s;
    logic [2*DATASIZE-1:0] eval_s;

    // Even parity flag of the full result word.
    function automatic logic even_parity(input logic [DATASIZE-1:0] v);
        return ~(^v);
    endfunction

    // ALU: returns {result, new F}. Subtracts are A + ~B + ~borrow_in, CY = borrow.
    function automatic logic [2*DATASIZE-1:0] alu_eval(input logic [2:0] op,
                                                       input logic [DATASIZE-1:0] a,
                                                       input logic [DATASIZE-1:0] b,
                                                       input logic cy);
        logic [DATASIZE:0]   sum;
        logic [4:0]          nib;
        logic [DATASIZE-1:0] res;
        logic [DATASIZE-1:0] f;
        logic                ac;
        logic                c;
        logic                cin;
        sum = '0;
        nib = 5'd0;
        res = '0;
        ac  = 1'b0;
        c   = 1'b0;
        cin = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                cin = (op == 3'd1) ? cy : 1'b0;
                sum = {1'b0, a} + {1'b0, b} + {{DATASIZE{1'b0}}, cin};
                nib = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
                res = sum[DATASIZE-1:0];
                c   = sum[DATASIZE];
                ac  = nib[4];
            end
            3'd2, 3'd3, 3'd7: begin
                cin = ~((op == 3'd3) ? cy : 1'b0);
                sum = {1'b0, a} + {1'b0, ~b} + {{DATASIZE{1'b0}}, cin};
                nib = {1'b0, a[3:0]} + {1'b0, ~b[3:0]} + {4'd0, cin};
                res = sum[DATASIZE-1:0];
                c   = ~sum[DATASIZE];
                ac  = nib[4];
            end
            3'd4: begin
                res = a & b;
                ac  = 1'b1;
            end
            3'd5: res = a ^ b;
            3'd6: res = a | b;
            default: res = a;
        endcase
        f    = '0;
        f[7] = res[DATASIZE-1];
        f[6] = (res == '0);
        f[4] = ac;
        f[2] = even_parity(res);
        f[1] = 1'b1;
        f[0] = c;
        return {res, f};
    endfunction

`ifdef ALUREG_SEQ_ROTATE_EN
    // Accumulator rotates: only CY changes in F.
    function automatic logic [2*DATASIZE-1:0] rot_eval(input logic [1:0] op,
                                                       input logic [DATASIZE-1:0] a,
                                                       input logic [DATASIZE-1:0] f_in);
        logic [DATASIZE-1:0] res;
        logic [DATASIZE-1:0] f;
        logic                c;
        case (op)
            2'd0: begin res = {a[DATASIZE-2:0], a[DATASIZE-1]}; c = a[DATASIZE-1]; end
            2'd1: begin res = {a[0], a[DATASIZE-1:1]};          c = a[0];          end
            2'd2: begin res = {a[DATASIZE-2:0], f_in[0]};       c = a[DATASIZE-1]; end
            default: begin res = {f_in[0], a[DATASIZE-1:1]};    c = a[0];          end
        endcase
        f    = f_in;
        f[0] = c;
        return {res, f};
    endfunction
`endif

    // Classify the latched opcode; anything touching M or outside the subset is rejected.
    always_comb begin
        kind_s = K_BAD;
        case (code_r[7:6])
            2'b01: begin
                if (code_r[5:3] != 3'd6 && code_r[2:0] != 3'd6) kind_s = K_MOV;
                else kind_s = K_BAD;
            end
            2'b10: begin
                if (code_r[2:0] != 3'd6) kind_s = K_ALU;
                else kind_s = K_BAD;
            end
            2'b11: begin
                if (code_r[2:0] == 3'd6) kind_s = K_ALUI;
                else kind_s = K_BAD;
            end
            default: begin
                if (code_r[2:0] == 3'd6 && code_r[5:3] != 3'd6) kind_s = K_MVI;
`ifdef ALUREG_SEQ_ROTATE_EN
                else if (code_r[2:0] == 3'd7 && code_r[5] == 1'b0) kind_s = K_ROT;
`endif
                else kind_s = K_BAD;
            end
        endcase
    end

    // Result and new flags from the latched operand; moves pass temp through, F kept.
    always_comb begin
        eval_s = {temp_r, regs_r[F_IDX]};
        case (kind_s)
            K_ALU, K_ALUI: eval_s = alu_eval(code_r[5:3], regs_r[A_IDX], temp_r, regs_r[F_IDX][0]);
`ifdef ALUREG_SEQ_ROTATE_EN
            K_ROT:         eval_s = rot_eval(code_r[4:3], regs_r[A_IDX], regs_r[F_IDX]);
`endif
            default:       eval_s = {temp_r, regs_r[F_IDX]};
        endcase
    end

    // Sequencer: accept, decode, fetch operand, compute, commit, and pulse done/err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            code_r  <= 8'd0;
            temp_r  <= '0;
            res_r   <= '0;
            flg_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= (i == F_IDX) ? F_RESET : '0;
            end
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (code_stb) begin
                        code_r  <= code_in;
                        busy_r  <= 1'b1;
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (kind_s)
                        K_MOV, K_ALU: begin
                            temp_r  <= regs_r[code_r[2:0]];
                            state_r <= ST_READ;
                        end
                        K_MVI, K_ALUI: state_r <= ST_WAITD;
                        K_ROT:         state_r <= ST_READ;
                        default: begin
                            err_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    endcase
                end
                ST_WAITD: begin
                    if (data_stb) begin
                        temp_r  <= data_in;
                        state_r <= ST_READ;
                    end
                end
                ST_READ: begin
                    res_r   <= eval_s[2*DATASIZE-1:DATASIZE];
                    flg_r   <= eval_s[DATASIZE-1:0];
                    state_r <= ST_WRITE;
                end
                ST_WRITE: begin
                    case (kind_s)
                        K_MOV, K_MVI: regs_r[code_r[5:3]] <= res_r;
                        K_ALU, K_ALUI: begin
                            if (code_r[5:3] != 3'd7) regs_r[A_IDX] <= res_r;
                            regs_r[F_IDX] <= flg_r;
                        end
                        K_ROT: begin
                            regs_r[A_IDX] <= res_r;
                            regs_r[F_IDX] <= flg_r;
                        end
                        default: ;
                    endcase
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_out   = regs_r[rd_sel];
    assign acc_out  = regs_r[A_IDX];
    assign flag_out = regs_r[F_IDX];
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_alureg_seq.sv
// Bench for alureg_seq: transaction-level reference model plus per-cycle output compare.
module tb_alureg_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] code_in;
    logic       code_stb;
    logic [7:0] data_in;
    logic       data_stb;
    logic [2:0] rd_sel;
    logic [7:0] rd_out;
    logic [7:0] acc_out;
    logic [7:0] flag_out;
    logic       busy;
    logic       done;
    logic       err;

    alureg_seq #(.DATASIZE(8)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_stb(code_stb),
        .data_in(data_in), .data_stb(data_stb), .rd_sel(rd_sel),
        .rd_out(rd_out), .acc_out(acc_out), .flag_out(flag_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_reg [8];     // architectural registers by rd_sel number: B,C,D,E,H,L,F,A
    logic exp_busy, exp_done, exp_err;
    bit   rd_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        m_reg[6] = 2;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    // 0 = rejected, 1 = register-timed op, 2 = immediate op
    function automatic int kind_of(input logic [7:0] c);
        logic [2:0] d;
        logic [2:0] s;
        d = c[5:3];
        s = c[2:0];
        case (c[7:6])
            2'b01:   return (d != 3'd6 && s != 3'd6) ? 1 : 0;
            2'b10:   return (s != 3'd6) ? 1 : 0;
            2'b11:   return (s == 3'd6) ? 2 : 0;
            default: begin
                if (s == 3'd6 && d != 3'd6) return 2;
`ifdef ALUREG_SEQ_ROTATE_EN
                if (c == 8'h07 || c == 8'h0F || c == 8'h17 || c == 8'h1F) return 1;
`endif
                return 0;
            end
        endcase
    endfunction

    // Architectural effect of one accepted opcode, in plain integer arithmetic.
    task automatic model_commit(input logic [7:0] c, input logic [7:0] data);
        int a, f, cy, b, r, t, nc, nac, op, bin, cin;
        a  = m_reg[7];
        f  = m_reg[6];
        cy = f & 1;
        if (c[7:6] == 2'b01) begin
            m_reg[c[5:3]] = m_reg[c[2:0]];
            return;
        end
        if (c[7:6] == 2'b00 && c[2:0] == 3'd6) begin
            m_reg[c[5:3]] = data;
            return;
        end
        if (c[7:6] == 2'b00) begin
            case (c)
                8'h07:   begin nc = a >> 7; r = ((a << 1) | nc) & 255; end
                8'h0F:   begin nc = a & 1;  r = (a >> 1) | (nc << 7); end
                8'h17:   begin nc = a >> 7; r = ((a << 1) | cy) & 255; end
                default: begin nc = a & 1;  r = (a >> 1) | (cy << 7); end
            endcase
            m_reg[7] = r;
            m_reg[6] = (f & 'hFE) | nc;
            return;
        end
        b  = (c[2:0] == 3'd6) ? int'(data) : m_reg[c[2:0]];
        op = c[5:3];
        nc = 0; nac = 0; r = 0;
        case (op)
            0, 1: begin
                cin = (op == 1) ? cy : 0;
                t = a + b + cin; r = t & 255; nc = (t > 255);
                nac = (((a & 15) + (b & 15) + cin) > 15);
            end
            2, 3, 7: begin
                bin = (op == 3) ? cy : 0;
                t = a - b - bin; r = t & 255; nc = (t < 0);
                nac = (((a & 15) - (b & 15) - bin) >= 0);
            end
            4: begin r = a & b; nac = 1; end
            5: r = a ^ b;
            default: r = a | b;
        endcase
        f = (r & 128) | ((r == 0) ? 64 : 0) | (nac ? 16 : 0)
            | (($countones(r[7:0]) % 2 == 0) ? 4 : 0) | 2 | nc;
        if (op != 7) m_reg[7] = r;
        m_reg[6] = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one opcode through the handshake and advance the expected outputs cycle by cycle.
    task automatic run_op(input logic [7:0] c, input logic [7:0] d, input int gap, input bit noise);
        int k;
        k = kind_of(c);
        code_in  = c;
        code_stb = 1'b1;
        data_stb = noise;          // data offered together with the code must be ignored
        data_in  = ~d;
        step();                    // E0
        exp_busy = 1'b1;
        if (k == 0) begin
            code_stb = 1'b0;
            data_stb = 1'b0;
            step();                // E1: reject
            exp_busy = 1'b0;
            exp_err  = 1'b1;
            step();
            exp_err  = 1'b0;
            return;
        end
        code_stb = noise;          // codes offered while busy must be ignored
        code_in  = 8'($urandom_range(0, 255));
        data_in  = 8'($urandom_range(0, 255));
        step();                    // E1
        if (k == 2) begin
            data_stb = 1'b0;
            for (int g = 0; g < gap; g++) step();
            data_in  = d;
            data_stb = 1'b1;
            step();                // Ed
            data_stb = noise;
            data_in  = 8'($urandom_range(0, 255));
        end
        step();                    // READ -> WRITE
        code_stb = 1'b0;
        data_stb = 1'b0;
        step();                    // commit
        model_commit(c, d);
        exp_done = 1'b1;
        step();                    // back to IDLE
        exp_done = 1'b0;
        exp_busy = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("err", err, exp_err);
            check("acc_out", acc_out, m_reg[7]);
            check("flag_out", flag_out, m_reg[6]);
            check("rd_out", rd_out, m_reg[rd_sel]);
            if (!rd_hold) rd_sel = 3'($urandom_range(0, 7));
        end
    end

    initial begin
        model_reset();
        rst = 1'b1; code_in = 8'd0; code_stb = 1'b0; data_in = 8'd0; data_stb = 1'b0; rd_sel = 3'd0;
        step(); step();
        rst = 1'b0;
        check("reset_acc", acc_out, 8'h00);
        check("reset_flag", flag_out, 8'h02);
        step();

        run_op(8'h3E, 8'hAA, 2, 1'b1);            // MVI A,AA
        check("mvi_a", acc_out, 8'hAA);
        check("mvi_f", flag_out, 8'h02);
        run_op(8'h47, 8'h00, 0, 1'b1);            // MOV B,A
        rd_hold = 1'b1; rd_sel = 3'd0; #1;
        check("mov_b", rd_out, 8'hAA);
        rd_hold = 1'b0;
        run_op(8'hAF, 8'h00, 0, 1'b0);            // XRA A
        check("xra_a", acc_out, 8'h00);
        check("xra_f", flag_out, 8'h46);
        run_op(8'h3E, 8'hFF, 0, 1'b0);
        run_op(8'hC6, 8'h01, 1, 1'b0);            // ADI 01
        check("adi_a", acc_out, 8'h00);
        check("adi_f", flag_out, 8'h57);
        run_op(8'h3E, 8'h00, 0, 1'b0);
        run_op(8'hD6, 8'h01, 3, 1'b1);            // SUI 01
        check("sui_a", acc_out, 8'hFF);
        check("sui_f", flag_out, 8'h87);
        run_op(8'h3E, 8'h05, 0, 1'b0);
        run_op(8'h06, 8'h05, 0, 1'b0);            // MVI B,05
        run_op(8'hB8, 8'h00, 0, 1'b0);            // CMP B
        check("cmp_a", acc_out, 8'h05);
        check("cmp_f", flag_out, 8'h56);
        run_op(8'h76, 8'h00, 0, 1'b0);            // HLT slot: rejected
        check("rej_a", acc_out, 8'h05);
        check("rej_f", flag_out, 8'h56);

        run_op(8'h3E, 8'h81, 0, 1'b0);
        run_op(8'h07, 8'h00, 0, 1'b0);            // RLC
`ifdef ALUREG_SEQ_ROTATE_EN
        check("rlc_a", acc_out, 8'h03);
        check("rlc_cy", flag_out[0], 1'b1);
`else
        check("rlc_rej_a", acc_out, 8'h81);
`endif

        // Asynchronous reset while ADD B sits in WRITE.
        run_op(8'h3E, 8'h12, 0, 1'b0);
        run_op(8'h06, 8'h34, 0, 1'b0);
        code_in = 8'h80; code_stb = 1'b1;
        step();                                   // E0
        exp_busy = 1'b1;
        code_stb = 1'b0;
        step(); step();                           // READ, WRITE
        rst = 1'b1;
        model_reset();
        step(); step();
        rst = 1'b0;
        check("rst_mid_a", acc_out, 8'h00);
        check("rst_mid_f", flag_out, 8'h02);
        step();
        run_op(8'h78, 8'h00, 0, 1'b0);            // MOV A,B after reset
        check("post_rst_mov", acc_out, 8'h00);

        for (int i = 0; i < 300; i++) begin
            logic [7:0] c;
            logic [7:0] d;
            c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) c = {c[7], c[7], c[5:3], 3'b110};
            if ($urandom_range(0, 7) == 0) c = {3'b000, 2'($urandom_range(0, 3)), 3'b111};
            d = 8'($urandom_range(0, 255));
            run_op(c, d, $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 3) == 0) step();
        end

        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/alureg_seq.md
Name: alureg_seq

Overview:
- Parametrised successor to the core ALU/register unit.
- Accepts one 8-bit 8085-style opcode per handshake and sequences temp load, register read, ALU and write-back internally. No external enc/end/rrd/rwr strobes.
- Sits between the fetch/decode front end and the register file and ALU datapath; reports busy, done and err.

Parameters:
DATASIZE, 8, data/register width; must be >= 8 (flag bit positions fixed at low 8 bits)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
code_in  in  8  opcode
code_stb  in  1  opcode valid; accepted on rising edge when busy=0
data_in  in  DATASIZE  immediate operand
data_stb  in  1  immediate valid; accepted only in WAITD
rd_sel  in  3  debug read select (0..7 = B,C,D,E,H,L,F,A)
rd_out  out  DATASIZE  combinational register at rd_sel
acc_out  out  DATASIZE  register A
flag_out  out  DATASIZE  register F
busy  out  1  high from the edge after acceptance until return to IDLE
done  out  1  one-cycle pulse, result committed
err  out  1  one-cycle pulse, opcode rejected

Behaviour:
- Reset (asynchronous, any state including mid-operation):
  - state IDLE; B,C,D,E,H,L,A = 0; F = 0x02 (bit1 fixed 1); internal temp = 0.
  - busy = 0, done = 0, err = 0; any pending opcode is discarded.
- Supported codes (ddd/sss: 0..5 = B..L, 7 = A):
  - MOV 01dddsss: dst <- src, flags unchanged.
  - MVI 00ddd110: dst <- data_in.
  - ALU r 10ooosss: A <- A op src.
  - ALU imm 11ooo110: A <- A op data_in.
  - ooo = 000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 AND, 101 XOR, 110 OR, 111 CMP.
- Rejected codes:
  - any ddd or sss = 110 (M, no memory path), including 0x76;
  - any other 00xxxxxx or 11xxxxxx pattern.
  - Response: err pulses in the cycle after DECODE, registers untouched, return to IDLE.
- FSM: IDLE -> DECODE -> (WAITD if immediate) -> READ -> WRITE -> DONE -> IDLE.
  - E0 accepts the code: code latched, busy rises.
  - Register op: E1 READ, E2 WRITE, E3 commit + DONE (done=1 for that cycle), E4 IDLE (busy=0).
  - Immediate op: WAITD holds indefinitely until data_stb is sampled at Ed; Ed+1 WRITE; Ed+2 commit, done=1; Ed+3 IDLE.
- Arithmetic:
  - DATASIZE-bit result. Carry/borrow out of MSB -> CY.
  - ADC/SBB use current CY as carry/borrow in.
  - SUB/SBB/CMP computed as A + ~B + ~bin; CY = borrow = inverted carry out.
- Flags (bit positions): S(7) = result MSB, Z(6) = result==0, AC(4), P(2) = even parity of full result, bit1 = 1, CY(0); all other bits 0.
  - AC for add ops = carry out of bit 3.
  - AC for sub ops = carry out of bit 3 of the A + ~B + ~bin sum.
  - AND: AC=1, CY=0. XOR/OR: AC=0, CY=0.
- CMP writes F only; A unchanged. MOV/MVI leave F unchanged.
- A write to A and to F commit on the same edge.
- Simultaneous and out-of-state inputs:
  - code_stb while busy is ignored (no queue).
  - data_stb outside WAITD is ignored.
  - code_stb and data_stb high together in IDLE: only the code is taken.
- rd_out, acc_out and flag_out reflect committed state.

Optional Feature:
ALUREG_SEQ_ROTATE_EN
- Defined: accepts RLC 0x07, RRC 0x0F, RAL 0x17, RAR 0x1F.
  - Operate on A; CY updated; all other flags unchanged.
  - Register-op timing (done at E3).
  - RLC/RRC rotate MSB/LSB into CY and around; RAL/RAR rotate through CY.
- Undefined: these codes take the rejected-code path and pulse err.

Test Plan:
- MVI A (0x3E) + data 0xAA -> done at Ed+2, A=0xAA, F=0x02; MOV B,A (0x47) -> B=0xAA, done at E3; XRA A (0xAF) -> A=0x00, F=0x46.
- A=0xFF, ADI (0xC6) data 0x01 -> A=0x00, F=0x57 (S=0, Z, AC, P, CY set).
- A=0x00, SUI (0xD6) data 0x01 -> A=0xFF, F=0x87 (S, P, CY set, AC=0).
- A=0x05, MVI B 0x05, CMP B (0xB8) -> A=0x05, F=0x56.
- Rejection and handshake:
  - Code 0x76 -> err=1 one cycle, done never, all registers unchanged.
  - code_stb during busy -> ignored, no second done.
- Reset mid-op: assert rst during WRITE of ADD B -> A=0x00, F=0x02, busy=0, done not pulsed; next MOV executes normally.
- With ALUREG_SEQ_ROTATE_EN: A=0x81, RLC -> A=0x03, CY=1. Without the macro: same code -> err pulse.
